uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter between NUM_REQ byte producers.
//  Round-robin arbitration; drives tx_din/tx_start into uart_tx, consumes tx_done.
//  Sits between requester logic and the uart_tx instance inside uart_top-level designs.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  GAP_CLKS      2     idle clocks inserted after each byte before next grant (0 allowed)
//  TIMEOUT_CLKS  4096  max clocks waiting for tx_done (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  tx_clk       in   1          clock, all logic rising-edge
//  tx_rst       in   1          async reset, active-high
//  req          in   NUM_REQ    per-requester "byte pending", level
//  req_data     in   NUM_REQ*8  byte of requester i at [8*i+7:8*i]
//  gnt          out  NUM_REQ    one-hot; bit i high while requester i's byte is in flight
//  done         out  NUM_REQ    one-cycle pulse on bit i when its byte finished
//  tx_din       out  8          byte to uart_tx, held stable from START through WAIT
//  tx_start     out  1          one-cycle start pulse to uart_tx
//  tx_done      in   1          one-cycle completion pulse from uart_tx
//  busy         out  1          high in any state other than IDLE
//  timeout_err  out  1          one-cycle pulse on watchdog expiry (0 without macro)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; last-grant pointer = NUM_REQ-1 (req[0] wins first).
//  - States: IDLE -> START -> WAIT -> GAP -> IDLE (GAP skipped when GAP_CLKS==0).
//  - IDLE: if |req, select first set bit scanning from pointer+1 upward, wrapping;
//    latch req_data of winner into tx_din, set gnt one-hot, go START. No req: stay.
//  - START: tx_start=1 for exactly this cycle; go WAIT. Latency: req seen in IDLE at
//    cycle N -> tx_start high at N+1.
//  - WAIT: hold gnt, tx_din. On tx_done: done[sel]=1 that cycle, gnt cleared,
//    pointer=sel, go GAP (or IDLE). tx_done in IDLE/START/GAP is ignored.
//  - GAP: count GAP_CLKS cycles with all outputs idle, then IDLE.
//  - Byte latched at grant: requester may drop req or change req_data after gnt
//    rises; transmission and done pulse still complete.
//  - Requester must drop req in the cycle after done or it is re-queued (fairness
//    still holds: pointer has advanced past it).
//  - Single requester continuously requesting: back-to-back bytes, gap 2+GAP_CLKS clocks
//    between tx_done and next tx_start (GAP + IDLE + START... measured tx_done->tx_start).
//  - Reset mid-WAIT: async clear to reset values; byte abandoned, no done pulse.
//  - busy = (state != IDLE).
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: WAIT counter starts at 0 on entry; if it reaches
//    TIMEOUT_CLKS-1 without tx_done: timeout_err=1 one cycle, gnt cleared, no done
//    pulse, pointer=sel, go GAP. tx_done on the expiry cycle wins (normal completion).
//  Not defined: WAIT holds indefinitely; no counter; timeout_err tied 0.
// TESTING
//  1 Reset, req=4'b0000 -> all outputs 0, busy=0 for 20 clocks.
//  2 req=4'b0001, req_data[7:0]=8'hA5 -> tx_start 1 clk after req, tx_din=8'hA5,
//    gnt=4'b0001; bench pulses tx_done -> done=4'b0001 same cycle, gnt=0.
//  3 req=4'b1111 held, data i=8'h10+i -> tx_din order 10,11,12,13,10; each done
//    once per round; tx_done->next tx_start exactly 2+GAP_CLKS clocks.
//  4 req=4'b0100 granted, then req drops and req_data changes to 8'hFF mid-WAIT
//    -> tx_din stays original, done[2] pulses on tx_done.
//  5 tx_rst asserted mid-WAIT -> outputs 0 immediately; after release req=4'b1000
//    with req=4'b0001 also set -> req[0] granted first.
//  6 With UART_ARB_TIMEOUT_EN, TIMEOUT_CLKS=64, no tx_done -> timeout_err pulse
//    64 clocks after tx_start cycle+1 entry, done stays 0, next requester granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CLKS     = 2,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           tx_din,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS < 2) begin : g_cfg_check
    $error("uart_tx_arbiter: unsupported parameter values");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         din_q, din_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      idx;
  logic               to_expire;

  // Scan from the slot after the last grant, wrapping, first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d  = (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
    to_expire = (state_q == S_WAIT) && !tx_done &&
                (32'(to_cnt_q) == TIMEOUT_CLKS - 1);
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    din_d     = din_q;
    gap_cnt_d = gap_cnt_q;
    done      = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          din_d      = req_data[{win, 3'b000} +: 8];
          state_d    = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // tx_done on the watchdog expiry cycle counts as a normal completion
        if (tx_done || to_expire) begin
          if (tx_done) done = gnt_q;
          gnt_d     = '0;
          ptr_d     = sel_q;
          gap_cnt_d = '0;
          state_d   = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (32'(gap_cnt_q) + 1 >= GAP_CLKS) state_d = S_IDLE;
        else                                gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(NUM_REQ - 1);
      sel_q     <= '0;
      gnt_q     <= '0;
      din_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      din_q     <= din_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_din      = din_q;
  assign tx_start    = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = to_expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed vectors, queue-based monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 64;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int EXP_TO = 1;
`else
  localparam int EXP_TO = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] gnt, done;
  logic [7:0]    tx_din;
  logic          tx_start;
  logic          tx_done = 1'b0;
  logic          busy, timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
    .tx_clk(clk), .tx_rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .done(done), .tx_din(tx_din), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    din;
    logic [NR-1:0] vec;
    int            at;
    bit            gap;
  } exp_t;

  exp_t q_start[$];
  exp_t q_done[$];
  int   q_to[$];

  int total = 0;
  int bad = 0;
  int to_pulses = 0;
  int last_end = 0;
  bit resp_en = 1'b0;
  int resp_lat = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_start(input logic [7:0] d, input logic [NR-1:0] v, input int at, input bit g);
    exp_t e;
    e.din = d; e.vec = v; e.at = at; e.gap = g;
    q_start.push_back(e);
  endtask

  task automatic push_done(input logic [7:0] d, input logic [NR-1:0] v);
    exp_t e;
    e.din = d; e.vec = v; e.at = -1; e.gap = 1'b0;
    q_done.push_back(e);
  endtask

  task automatic wait_q(input string name, input int ns, input int nd, input int max);
    int n = 0;
    while ((q_start.size() > ns || q_done.size() > nd || q_to.size() > 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (q_start.size() > ns || q_done.size() > nd || q_to.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timed out: start_q=%0d done_q=%0d to_q=%0d", name,
               q_start.size(), q_done.size(), q_to.size());
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Stand-in for uart_tx: answers each start pulse with tx_done resp_lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && resp_en) begin
        repeat (resp_lat) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    bit   chk_gclr;
    chk_gclr = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_gclr) begin
        check("gnt_cleared", 64'(gnt), 64'(0));
        chk_gclr = 1'b0;
      end
      if (tx_start) begin
        if (q_start.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start tx_din=%0h gnt=%0b required=no start", tx_din, gnt);
        end else begin
          e = q_start.pop_front();
          check("start_din", 64'(tx_din), 64'(e.din));
          check("start_gnt", 64'(gnt), 64'(e.vec));
          if (e.at >= 0) check("start_latency", 64'(cyc), 64'(e.at));
          if (e.gap) check("end_to_start", 64'(cyc - last_end), 64'(2 + GAP));
        end
      end
      if (done != '0) begin
        last_end = cyc;
        chk_gclr = 1'b1;
        if (q_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done done=%0b required=no pulse", done);
        end else begin
          e = q_done.pop_front();
          check("done_vec", 64'(done), 64'(e.vec));
          check("done_din_held", 64'(tx_din), 64'(e.din));
        end
      end
      if (timeout_err) begin
        last_end = cyc;
        chk_gclr = 1'b1;
        to_pulses++;
        if (q_to.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_timeout at cycle %0d required=no pulse", cyc);
        end else begin
          check("timeout_cycle", 64'(cyc), 64'(q_to.pop_front()));
          check("timeout_no_done", 64'(done), 64'(0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {gnt, done, tx_din, tx_start, busy, timeout_err}, 64'(0));
    end

    // Single requester
    resp_en = 1'b1;
    resp_lat = 3;
    tick();
    req_data = '0;
    req_data[7:0] = 8'hA5;
    push_start(8'hA5, 4'b0001, cyc + 1, 1'b0);
    push_done(8'hA5, 4'b0001);
    req = 4'b0001;
    wait_q("single_done", 0, 0, 50);
    tick();
    req = '0;
    repeat (6) tick();

    // All four requesting: round-robin order from reset pointer
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    push_start(8'h10, 4'b0001, cyc + 1, 1'b0);
    push_start(8'h11, 4'b0010, -1, 1'b1);
    push_start(8'h12, 4'b0100, -1, 1'b1);
    push_start(8'h13, 4'b1000, -1, 1'b1);
    push_start(8'h10, 4'b0001, -1, 1'b1);
    for (int i = 0; i < 5; i++) push_done(req_data[8*(i%4) +: 8], 4'(1 << (i % 4)));
    req = 4'b1111;
    wait_q("rr_starts", 0, 5, 200);
    tick();
    req = '0;
    wait_q("rr_dones", 0, 0, 50);
    repeat (6) tick();

    // Byte latched at grant; requester changes data mid-WAIT
    do_reset();
    resp_lat = 6;
    req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    push_start(8'h5C, 4'b0100, cyc + 1, 1'b0);
    push_done(8'h5C, 4'b0100);
    req = 4'b0100;
    wait_q("latch_start", 0, 1, 50);
    tick();
    req = '0;
    req_data[23:16] = 8'hFF;
    wait_q("latch_done", 0, 0, 50);
    repeat (6) tick();

    // Reset mid-WAIT, then fairness restarts at req[0]
    do_reset();
    resp_en = 1'b0;
    req_data = {8'h77, 8'h00, 8'h00, 8'h00};
    push_start(8'h77, 4'b1000, cyc + 1, 1'b0);
    req = 4'b1000;
    wait_q("abandon_start", 0, 0, 50);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {gnt, done, tx_din, tx_start, busy, timeout_err}, 64'(0));
    repeat (2) tick();
    resp_en = 1'b1;
    resp_lat = 3;
    req_data[7:0] = 8'h31;
    req = 4'b1001;
    push_start(8'h31, 4'b0001, cyc + 1, 1'b0);
    push_done(8'h31, 4'b0001);
    push_start(8'h77, 4'b1000, -1, 1'b1);
    push_done(8'h77, 4'b1000);
    rst = 1'b0;
    wait_q("post_reset_first", 1, 1, 50);
    tick();
    req = 4'b1000;
    wait_q("post_reset_second", 0, 1, 50);
    tick();
    req = '0;
    wait_q("post_reset_done", 0, 0, 50);
    repeat (6) tick();

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog expiry, then next requester served
    do_reset();
    resp_en = 1'b0;
    req_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    push_start(8'hB0, 4'b0001, cyc + 1, 1'b0);
    q_to.push_back(cyc + 1 + TO);
    push_start(8'hB1, 4'b0010, -1, 1'b1);
    push_done(8'hB1, 4'b0010);
    req = 4'b0011;
    begin
      int n = 0;
      while (q_to.size() != 0 && n < TO + 20) begin
        @(negedge clk);
        n++;
      end
    end
    tick();
    resp_en = 1'b1;
    req = 4'b0010;
    wait_q("after_timeout_start", 0, 1, 50);
    tick();
    req = '0;
    wait_q("after_timeout_done", 0, 0, 50);
    repeat (6) tick();
`endif

    check("queues_drained", 64'(q_start.size() + q_done.size() + q_to.size()), 64'(0));
    check("timeout_pulses", 64'(to_pulses), 64'(EXP_TO));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
